point_scheduler: RTL and testbench
==================================

# point_scheduler

Sequencing controller for the food-point resource in the snake game. It owns the single active point position and decides when the point moves. Eat requests from both snakes are shared onto one regeneration engine. The engine draws candidate coordinates from a pair of 5-bit LFSRs and probes the map until it finds an EMPTY tile. It sits between the per-snake movement/collision logic (requesters) and the map-update stage, which writes POINT at the committed coordinates.

## Interface
Parameters:
- MAX_TRIES, 16: probe attempts per regeneration before giving up.
- X_RANGE, 30: playable columns; candidate x = (lfsr_x % X_RANGE) + 1.
- Y_RANGE, 22: playable rows; candidate y = (lfsr_y % Y_RANGE) + 1.

Ports:
- clk_75  in  1  system clock, all logic on posedge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse on MENU→GAME transition.
- seed_x, seed_y  in  5  seeds, sampled only with start.
- eat1_req, eat2_req  in  1  snake 1/2 head entered point tile; level, held until the matching ack.
- eat1_ack, eat2_ack  out  1  one-cycle acknowledge pulses.
- tile_rd_x, tile_rd_y  out  5  probe address to the map (combinational from LFSR regs).
- tile_rd_empty  in  1  map tile at probe address is EMPTY; combinational, same cycle.
- point_x, point_y  out  5  committed point coordinates.
- point_valid  out  1  point_x/y hold a placed point.
- busy  out  1  FSM not in IDLE.
- place_fail  out  1  one-cycle pulse when MAX_TRIES is exhausted.

## Operation
- States: IDLE, PROBE.
- Reset values: state IDLE; lfsr_x = lfsr_y = 5'd1; tries 0; all outputs 0.
- LFSR step: next = {l[3:0], l[4]^l[2]}, polynomial x^5+x^3+1, period 31. The all-zero state is never loaded.
- start, in any state: lfsr_x ← (seed_x==0 ? 1 : seed_x), likewise lfsr_y. Then tries ← 0, point_valid ← 0, state ← PROBE.
  - start overrides everything else in the same cycle.
  - Pending requests are not acked.
- IDLE with point_valid=1 and either request high:
  - Ack every asserted request in the same cycle. Simultaneous eat1/eat2 are both acked, with a single regeneration.
  - point_valid ← 0; advance both LFSRs once; tries ← 0; state ← PROBE.
- Requests in IDLE with point_valid=0 are ignored and stay pending.
- PROBE:
  - tile_rd_x/y = candidate.
  - If tile_rd_empty=1: point_x/y ← candidate, point_valid ← 1, state ← IDLE.
  - Else if tries == MAX_TRIES-1: place_fail pulse, point_valid stays 0, state ← IDLE.
  - Else advance both LFSRs and increment tries.
- Width: % and +1 are computed at 5 bits; results are always within 1..X_RANGE and 1..Y_RANGE.
- A failed placement leaves requests unserviceable until the next start.

## Timing
- Request seen in IDLE at cycle n → ack pulse and busy=1 from cycle n+1. First probe is at n+1; best case point_valid=1 at n+2.
- Each rejected candidate adds exactly one cycle. Worst case is place_fail at n+MAX_TRIES, then IDLE on the following cycle.
- start at cycle n → first probe at n+1, valid at n+2 in the best case.
- The requester must drop its request in the cycle after the ack. A request still high one cycle after ack is treated as a new request once point_valid returns.
- Asserting rst_n low mid-PROBE forces reset values immediately. No partial commit is ever visible.

## Structure
- In snake_pkg: the point_sched_state enum, and the constants X_RANGE=30 and Y_RANGE=22, shared with the point writer.
- One sub-module, lfsr5: a 5-bit register with load, step, and a nonzero guard. It is instantiated twice (x and y).
- The FSM, try counter and request/ack logic stay in point_scheduler.

## Test plan
- Reset, then start with seed (7,3) and map all empty → probe (8,4) at start+1; point=(8,4), valid at start+2; acks stay 0.
- eat1_req in IDLE, map empty → eat1_ack one cycle later; next point (16,7) two cycles after the request.
- eat1_req, with (16,7) occupied and (2,14) empty → probes (16,7) then (2,14); valid one cycle later than the best case.
- eat1_req and eat2_req asserted in the same cycle → both acks in the same cycle; exactly one regeneration.
- tile_rd_empty held at 0 → place_fail pulse exactly MAX_TRIES (16) cycles after the request; point_valid=0; then IDLE.
- rst_n low mid-PROBE → all outputs 0 asynchronously. start with seed (0,0) → LFSRs load 1, first candidate is (2,2).

Source files
------------

// File: rtl/snake_pkg.sv
// Shared snake-game types, playfield constants and LFSR/coordinate helpers.
package snake_pkg;

  localparam int unsigned X_RANGE = 30;
  localparam int unsigned Y_RANGE = 22;

  typedef enum logic [0:0] {
    PS_IDLE  = 1'b0,
    PS_PROBE = 1'b1
  } point_sched_state_e;

  // One step of the x^5+x^3+1 Fibonacci LFSR (period 31 over nonzero states).
  function automatic logic [4:0] lfsr5_next(input logic [4:0] l);
    return {l[3:0], l[4] ^ l[2]};
  endfunction

  // Map an LFSR value onto a 1-based playfield coordinate, all at 5 bits.
  function automatic logic [4:0] coord_map(input logic [4:0] l, input logic [4:0] range);
    return (l % range) + 5'd1;
  endfunction

endpackage

// File: rtl/lfsr5.sv
// 5-bit LFSR register with seed load, step and a guard against the all-zero state.
module lfsr5 (
  input  logic       clk_75,
  input  logic       rst_n,
  input  logic       load,
  input  logic [4:0] seed,
  input  logic       step,
  output logic [4:0] q
);

  import snake_pkg::lfsr5_next;

  // Load has priority over step; a zero seed is replaced by 1 so the LFSR never locks up.
  always_ff @(posedge clk_75 or negedge rst_n) begin
    if (!rst_n) begin
      q <= 5'd1;
    end else if (load) begin
      q <= (seed == 5'd0) ? 5'd1 : seed;
    end else if (step) begin
      q <= lfsr5_next(q);
    end
  end

endmodule

// File: rtl/point_scheduler.sv
// Food-point scheduler: arbitrates eat requests and searches the map for an EMPTY tile.
module point_scheduler #(
  parameter int unsigned MAX_TRIES = 16,
  parameter int unsigned X_RANGE   = snake_pkg::X_RANGE,
  parameter int unsigned Y_RANGE   = snake_pkg::Y_RANGE
) (
  input  logic       clk_75,
  input  logic       rst_n,
  input  logic       start,
  input  logic [4:0] seed_x,
  input  logic [4:0] seed_y,
  input  logic       eat1_req,
  input  logic       eat2_req,
  output logic       eat1_ack,
  output logic       eat2_ack,
  output logic [4:0] tile_rd_x,
  output logic [4:0] tile_rd_y,
  input  logic       tile_rd_empty,
  output logic [4:0] point_x,
  output logic [4:0] point_y,
  output logic       point_valid,
  output logic       busy,
  output logic       place_fail
);

  import snake_pkg::point_sched_state_e;
  import snake_pkg::PS_IDLE;
  import snake_pkg::PS_PROBE;
  import snake_pkg::coord_map;

  localparam int unsigned TRIES_W  = (MAX_TRIES > 1) ? $clog2(MAX_TRIES) : 1;
  localparam logic [4:0]  X_RANGE5 = 5'(X_RANGE);
  localparam logic [4:0]  Y_RANGE5 = 5'(Y_RANGE);
  localparam logic [TRIES_W-1:0] LAST_TRY = TRIES_W'(MAX_TRIES - 1);

  point_sched_state_e state_q, state_d;
  logic [TRIES_W-1:0] tries_q, tries_d;
  logic [4:0]         point_x_d, point_y_d;
  logic               point_valid_d;
  logic               eat1_ack_d, eat2_ack_d;
  logic               lfsr_load, lfsr_step;
  logic               fail_c;
  logic [4:0]         lfsr_x, lfsr_y;
  logic [4:0]         cand_x, cand_y;

  lfsr5 u_lfsr_x (
    .clk_75 (clk_75),
    .rst_n  (rst_n),
    .load   (lfsr_load),
    .seed   (seed_x),
    .step   (lfsr_step),
    .q      (lfsr_x)
  );

  lfsr5 u_lfsr_y (
    .clk_75 (clk_75),
    .rst_n  (rst_n),
    .load   (lfsr_load),
    .seed   (seed_y),
    .step   (lfsr_step),
    .q      (lfsr_y)
  );

  // Candidate coordinates derived from the current LFSR pair.
  assign cand_x = coord_map(lfsr_x, X_RANGE5);
  assign cand_y = coord_map(lfsr_y, Y_RANGE5);

  // Probe address is only driven while searching, so nothing leaks out of IDLE/reset.
  assign tile_rd_x  = (state_q == PS_PROBE) ? cand_x : 5'd0;
  assign tile_rd_y  = (state_q == PS_PROBE) ? cand_y : 5'd0;
  assign busy       = (state_q != PS_IDLE);
  assign place_fail = fail_c;

  // State and output registers.
  always_ff @(posedge clk_75 or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= PS_IDLE;
      tries_q     <= '0;
      point_x     <= 5'd0;
      point_y     <= 5'd0;
      point_valid <= 1'b0;
      eat1_ack    <= 1'b0;
      eat2_ack    <= 1'b0;
    end else begin
      state_q     <= state_d;
      tries_q     <= tries_d;
      point_x     <= point_x_d;
      point_y     <= point_y_d;
      point_valid <= point_valid_d;
      eat1_ack    <= eat1_ack_d;
      eat2_ack    <= eat2_ack_d;
    end
  end

  // Next-state, LFSR control and request/ack decisions; start overrides everything.
  always_comb begin
    state_d       = state_q;
    tries_d       = tries_q;
    point_x_d     = point_x;
    point_y_d     = point_y;
    point_valid_d = point_valid;
    eat1_ack_d    = 1'b0;
    eat2_ack_d    = 1'b0;
    lfsr_load     = 1'b0;
    lfsr_step     = 1'b0;
    fail_c        = 1'b0;

    if (start) begin
      lfsr_load     = 1'b1;
      tries_d       = '0;
      point_valid_d = 1'b0;
      state_d       = PS_PROBE;
    end else begin
      case (state_q)
        PS_IDLE: begin
          // Both requests share one regeneration; requests without a placed point wait.
          if (point_valid && (eat1_req || eat2_req)) begin
            eat1_ack_d    = eat1_req;
            eat2_ack_d    = eat2_req;
            point_valid_d = 1'b0;
            lfsr_step     = 1'b1;
            tries_d       = '0;
            state_d       = PS_PROBE;
          end
        end
        PS_PROBE: begin
          if (tile_rd_empty) begin
            point_x_d     = cand_x;
            point_y_d     = cand_y;
            point_valid_d = 1'b1;
            state_d       = PS_IDLE;
          end else if (tries_q == LAST_TRY) begin
            fail_c  = 1'b1;
            state_d = PS_IDLE;
          end else begin
            lfsr_step = 1'b1;
            tries_d   = tries_q + TRIES_W'(1);
          end
        end
        default: state_d = PS_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_point_scheduler.sv
// Self-checking bench for point_scheduler: directed scenarios plus randomized maps and seeds.
module tb_point_scheduler;

  localparam int MAXT = 16;
  localparam int XR   = 30;
  localparam int YR   = 22;

  logic       clk_75 = 1'b0;
  logic       rst_n;
  logic       start;
  logic [4:0] seed_x, seed_y;
  logic       eat1_req, eat2_req;
  logic       eat1_ack, eat2_ack;
  logic [4:0] tile_rd_x, tile_rd_y;
  logic       tile_rd_empty;
  logic [4:0] point_x, point_y;
  logic       point_valid, busy, place_fail;

  logic occ [0:31][0:31];
  logic force_full;

  int checks = 0;
  int errors = 0;

  // Reference model state: LFSR pair as plain integers and the placed point.
  int mx, my;
  bit mvalid;

  always #5 clk_75 = ~clk_75;

  assign tile_rd_empty = !force_full && !occ[tile_rd_x][tile_rd_y];

  point_scheduler #(.MAX_TRIES(MAXT), .X_RANGE(XR), .Y_RANGE(YR)) dut (
    .clk_75        (clk_75),
    .rst_n         (rst_n),
    .start         (start),
    .seed_x        (seed_x),
    .seed_y        (seed_y),
    .eat1_req      (eat1_req),
    .eat2_req      (eat2_req),
    .eat1_ack      (eat1_ack),
    .eat2_ack      (eat2_ack),
    .tile_rd_x     (tile_rd_x),
    .tile_rd_y     (tile_rd_y),
    .tile_rd_empty (tile_rd_empty),
    .point_x       (point_x),
    .point_y       (point_y),
    .point_valid   (point_valid),
    .busy          (busy),
    .place_fail    (place_fail)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // x^5+x^3+1 step expressed arithmetically: shift left in 5 bits, feed back bit4 xor bit2.
  function automatic int mstep(input int l);
    return ((l * 2) % 32) + ((((l / 16) % 2) + ((l / 4) % 2)) % 2);
  endfunction

  function automatic int mcand(input int l, input int r);
    return (l % r) + 1;
  endfunction

  task automatic clear_map();
    for (int x = 0; x < 32; x++)
      for (int y = 0; y < 32; y++)
        occ[x][y] = 1'b0;
  endtask

  task automatic random_map(input int density);
    for (int x = 0; x < 32; x++)
      for (int y = 0; y < 32; y++)
        occ[x][y] = ($urandom_range(0, 99) < density);
  endtask

  // Called at the negedge of the first probe cycle; follows the search cycle by cycle.
  task automatic probe_phase();
    bit done;
    done = 1'b0;
    for (int k = 0; k < MAXT && !done; k++) begin
      int  cx, cy;
      bit  emp;
      cx  = mcand(mx, XR);
      cy  = mcand(my, YR);
      emp = !force_full && !occ[cx][cy];
      chk("probe_x", 32'(tile_rd_x), 32'(cx));
      chk("probe_y", 32'(tile_rd_y), 32'(cy));
      chk("probe_busy", 32'(busy), 32'd1);
      if (emp) begin
        chk("no_fail", 32'(place_fail), 32'd0);
        @(negedge clk_75);
        chk("commit_valid", 32'(point_valid), 32'd1);
        chk("commit_x", 32'(point_x), 32'(cx));
        chk("commit_y", 32'(point_y), 32'(cy));
        chk("commit_idle", 32'(busy), 32'd0);
        mvalid = 1'b1;
        done   = 1'b1;
      end else if (k == MAXT - 1) begin
        chk("fail_pulse", 32'(place_fail), 32'd1);
        @(negedge clk_75);
        chk("fail_idle", 32'(busy), 32'd0);
        chk("fail_valid", 32'(point_valid), 32'd0);
        chk("fail_pulse_end", 32'(place_fail), 32'd0);
        mvalid = 1'b0;
        done   = 1'b1;
      end else begin
        chk("no_fail", 32'(place_fail), 32'd0);
        mx = mstep(mx);
        my = mstep(my);
        @(negedge clk_75);
        chk("ack1_quiet", 32'(eat1_ack), 32'd0);
        chk("ack2_quiet", 32'(eat2_ack), 32'd0);
      end
    end
  endtask

  task automatic do_start(input logic [4:0] sx, input logic [4:0] sy);
    start  = 1'b1;
    seed_x = sx;
    seed_y = sy;
    @(negedge clk_75);
    start    = 1'b0;
    eat1_req = 1'b0;
    eat2_req = 1'b0;
    mx = (sx == 5'd0) ? 1 : int'(sx);
    my = (sy == 5'd0) ? 1 : int'(sy);
    chk("start_ack1", 32'(eat1_ack), 32'd0);
    chk("start_ack2", 32'(eat2_ack), 32'd0);
    chk("start_valid", 32'(point_valid), 32'd0);
    probe_phase();
  endtask

  task automatic do_req(input logic r1, input logic r2);
    eat1_req = r1;
    eat2_req = r2;
    @(negedge clk_75);
    chk("req_ack1", 32'(eat1_ack), 32'(r1));
    chk("req_ack2", 32'(eat2_ack), 32'(r2));
    chk("req_valid_drop", 32'(point_valid), 32'd0);
    eat1_req = 1'b0;
    eat2_req = 1'b0;
    mx = mstep(mx);
    my = mstep(my);
    probe_phase();
    chk("ack1_single", 32'(eat1_ack), 32'd0);
    chk("ack2_single", 32'(eat2_ack), 32'd0);
  endtask

  initial begin
    rst_n      = 1'b0;
    start      = 1'b0;
    seed_x     = 5'd0;
    seed_y     = 5'd0;
    eat1_req   = 1'b0;
    eat2_req   = 1'b0;
    force_full = 1'b0;
    mvalid     = 1'b0;
    clear_map();

    // Reset state
    #2;
    chk("rst_valid", 32'(point_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_px", 32'(point_x), 32'd0);
    chk("rst_ack1", 32'(eat1_ack), 32'd0);
    chk("rst_fail", 32'(place_fail), 32'd0);
    @(negedge clk_75);
    rst_n = 1'b1;
    @(negedge clk_75);

    // Start with seed (7,3) on an empty map
    do_start(5'd7, 5'd3);
    chk("first_point_x", 32'(point_x), 32'd8);
    chk("first_point_y", 32'(point_y), 32'd4);

    // Single eat on an empty map
    do_req(1'b1, 1'b0);
    chk("second_point_x", 32'(point_x), 32'd16);
    chk("second_point_y", 32'(point_y), 32'd7);

    // First candidate occupied, second free
    occ[16][7] = 1'b1;
    mx = 7; my = 3;
    do_start(5'd7, 5'd3);
    do_req(1'b1, 1'b0);
    chk("retry_point_x", 32'(point_x), 32'd2);
    chk("retry_point_y", 32'(point_y), 32'd14);
    clear_map();

    // Simultaneous requests, one regeneration
    do_req(1'b1, 1'b1);

    // Map full: exhaust all tries
    force_full = 1'b1;
    do_req(1'b0, 1'b1);

    // Requests are ignored without a placed point
    eat1_req = 1'b1;
    repeat (3) begin
      @(negedge clk_75);
      chk("ignored_ack", 32'(eat1_ack), 32'd0);
      chk("ignored_busy", 32'(busy), 32'd0);
    end
    force_full = 1'b0;
    do_start(5'd19, 5'd11);

    // Asynchronous reset in the middle of a search
    force_full = 1'b1;
    start  = 1'b1;
    seed_x = 5'd5;
    seed_y = 5'd9;
    @(negedge clk_75);
    start = 1'b0;
    repeat (3) @(negedge clk_75);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_valid", 32'(point_valid), 32'd0);
    chk("arst_px", 32'(point_x), 32'd0);
    chk("arst_py", 32'(point_y), 32'd0);
    chk("arst_rdx", 32'(tile_rd_x), 32'd0);
    chk("arst_rdy", 32'(tile_rd_y), 32'd0);
    chk("arst_fail", 32'(place_fail), 32'd0);
    chk("arst_ack", 32'({eat1_ack, eat2_ack}), 32'd0);
    @(negedge clk_75);
    rst_n      = 1'b1;
    force_full = 1'b0;
    mvalid     = 1'b0;
    @(negedge clk_75);

    // Zero seed loads 1 -> first candidate (2,2)
    do_start(5'd0, 5'd0);
    chk("zero_seed_x", 32'(point_x), 32'd2);
    chk("zero_seed_y", 32'(point_y), 32'd2);

    // Randomized maps, seeds and request mixes
    for (int it = 0; it < 60; it++) begin
      random_map(int'($urandom_range(0, 95)));
      if (!mvalid || ($urandom_range(0, 9) == 0)) begin
        do_start(5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
      end else begin
        int sel;
        sel = int'($urandom_range(1, 3));
        do_req(sel[0], sel[1]);
      end
      repeat (int'($urandom_range(0, 2))) @(negedge clk_75);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
